// File: rtl/floppy_head_stepper_pkg.sv
// Shared definitions for the floppy head-positioning logic: opcodes, FSM state
// encoding and the sizing helper used for the shared step/settle timer.
package floppy_pkg;

   localparam int TRACK_W     = 7;
   localparam int FPGA_CLK_HZ = 50_000_000;

   localparam logic [1:0] OP_SEEK  = 2'b00;
   localparam logic [1:0] OP_RECAL = 2'b01;

   localparam logic [2:0] ST_IDLE   = 3'd0;
   localparam logic [2:0] ST_PULSE  = 3'd1;
   localparam logic [2:0] ST_GAP    = 3'd2;
   localparam logic [2:0] ST_SETTLE = 3'd3;
   localparam logic [2:0] ST_FINISH = 3'd4;

   function automatic int max3(input int a, input int b, input int c);
      int m;
      m = a;
      if (b > m) begin
         m = b;
      end else begin
         m = m;
      end
      if (c > m) begin
         m = c;
      end else begin
         m = m;
      end
      return m;
   endfunction

endpackage

// File: rtl/floppy_head_stepper_sync2.sv
// Generic two-flop synchronizer for asynchronous drive status pins
// (TRK00, INDEX, DSKCHG, WPT); the reset value is chosen per pin.
module sync2 #(
   parameter int             W       = 1,
   parameter logic [W-1:0]   RST_VAL = {W{1'b0}}
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic [W-1:0] d,
   output logic [W-1:0] q
);

   logic [W-1:0] meta_q;
   logic [W-1:0] sync_q;

   // two-stage capture of the asynchronous input
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         meta_q <= RST_VAL;
         sync_q <= RST_VAL;
      end else begin
         meta_q <= d;
         sync_q <= meta_q;
      end
   end

   assign q = sync_q;

endmodule

// File: rtl/floppy_head_stepper.sv
// Head-positioning controller: turns SEEK/RECAL commands into timed active-low
// STEP pulses with DIR, tracks the cylinder and reports done/error after settle.
module floppy_head_stepper
   import floppy_pkg::*;
#(
   parameter int STEP_PULSE_CYC = 50,
   parameter int STEP_RATE_CYC  = 150000,
   parameter int SETTLE_CYC     = 750000,
   parameter int MAX_TRACK      = 79,
   parameter int RECAL_LIMIT    = 85
) (
   input  logic               fpga_clk,
   input  logic               RESET_IN_N,
   input  logic               cmd_valid,
   output logic               cmd_ready,
   input  logic [1:0]         cmd_op,
   input  logic [TRACK_W-1:0] cmd_track,
   output logic               done,
   output logic               error,
   output logic [TRACK_W-1:0] cur_track,
   output logic               track_valid,
   input  logic               TRK00,
   output logic               STEP,
   output logic               DIR
);

   localparam int TMR_MAX = max3(STEP_PULSE_CYC, STEP_RATE_CYC, SETTLE_CYC);
   localparam int TMR_W   = $clog2(TMR_MAX + 1);
   localparam int CNT_W   = $clog2(RECAL_LIMIT + 1);

   localparam logic [TMR_W-1:0]   PULSE_LAST  = TMR_W'(STEP_PULSE_CYC - 1);
   localparam logic [TMR_W-1:0]   RATE_LAST   = TMR_W'(STEP_RATE_CYC - 1);
   localparam logic [TMR_W-1:0]   SETTLE_LAST = TMR_W'(SETTLE_CYC - 1);
   localparam logic [TMR_W-1:0]   TMR_ZERO    = {TMR_W{1'b0}};
   localparam logic [CNT_W-1:0]   RECAL_LIM   = CNT_W'(RECAL_LIMIT);
   localparam logic [CNT_W-1:0]   CNT_ZERO    = {CNT_W{1'b0}};
   localparam logic [TRACK_W-1:0] MAX_TRK     = TRACK_W'(MAX_TRACK);
   localparam logic [TRACK_W-1:0] TRK_ZERO    = {TRACK_W{1'b0}};

   logic [2:0]         state_q, state_d;
   logic [TMR_W-1:0]   timer_q, timer_d;
   logic [CNT_W-1:0]   step_cnt_q, step_cnt_d;
   logic [TRACK_W-1:0] cur_track_q, cur_track_d;
   logic [TRACK_W-1:0] target_q, target_d;
   logic               track_valid_q, track_valid_d;
   logic               is_recal_q, is_recal_d;
   logic               err_q, err_d;
   logic               error_q, error_d;
   logic               done_q, done_d;
   logic               cmd_ready_q, cmd_ready_d;
   logic               step_q, step_d;
   logic               dir_q, dir_d;
   logic               trk00_sync;
   logic               trk0;
   logic               accept;

   sync2 #(
      .W       (1),
      .RST_VAL (1'b1)
   ) u_trk00_sync (
      .clk   (fpga_clk),
      .rst_n (RESET_IN_N),
      .d     (TRK00),
      .q     (trk00_sync)
   );

   assign trk0   = ~trk00_sync;
   assign accept = cmd_valid & cmd_ready_q & (state_q == ST_IDLE);

   // next-state and datapath for the whole positioning sequence
   always_comb begin
      state_d       = state_q;
      timer_d       = timer_q;
      step_cnt_d    = step_cnt_q;
      cur_track_d   = cur_track_q;
      target_d      = target_q;
      track_valid_d = track_valid_q;
      is_recal_d    = is_recal_q;
      err_d         = err_q;
      error_d       = error_q;
      dir_d         = dir_q;
      done_d        = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (accept) begin
               err_d      = 1'b0;
               error_d    = 1'b0;
               timer_d    = TMR_ZERO;
               step_cnt_d = CNT_ZERO;
               if (cmd_op == OP_RECAL) begin
                  is_recal_d = 1'b1;
                  dir_d      = 1'b1;
                  if (trk0) begin
                     // already parked on track 0: recalibrated without stepping
                     cur_track_d   = TRK_ZERO;
                     track_valid_d = 1'b1;
                     state_d       = ST_SETTLE;
                  end else begin
                     state_d = ST_PULSE;
                  end
               end else if ((cmd_op != OP_SEEK) || !track_valid_q || (cmd_track > MAX_TRK)) begin
                  err_d   = 1'b1;
                  state_d = ST_FINISH;
               end else if (cmd_track == cur_track_q) begin
                  is_recal_d = 1'b0;
                  state_d    = ST_SETTLE;
               end else begin
                  is_recal_d = 1'b0;
                  dir_d      = (cmd_track < cur_track_q);
                  target_d   = cmd_track;
                  state_d    = ST_PULSE;
               end
            end else begin
               state_d = ST_IDLE;
            end
         end

         ST_PULSE: begin
            timer_d = timer_q + 1'b1;
            if (timer_q == PULSE_LAST) begin
               state_d = ST_GAP;
               if (dir_q) begin
                  if (cur_track_q != TRK_ZERO) begin
                     cur_track_d = cur_track_q - 1'b1;
                  end else begin
                     cur_track_d = TRK_ZERO;
                  end
               end else begin
                  if (cur_track_q != MAX_TRK) begin
                     cur_track_d = cur_track_q + 1'b1;
                  end else begin
                     cur_track_d = MAX_TRK;
                  end
               end
               if (is_recal_q) begin
                  step_cnt_d = step_cnt_q + 1'b1;
               end else begin
                  step_cnt_d = step_cnt_q;
               end
            end else begin
               state_d = ST_PULSE;
            end
         end

         ST_GAP: begin
            if (timer_q == RATE_LAST) begin
               timer_d = TMR_ZERO;
               if (is_recal_q && trk0) begin
                  cur_track_d   = TRK_ZERO;
                  track_valid_d = 1'b1;
                  state_d       = ST_SETTLE;
               end else if (is_recal_q && (step_cnt_q == RECAL_LIM)) begin
                  // never saw track 0: position is unknown, skip the settle
                  err_d         = 1'b1;
                  track_valid_d = 1'b0;
                  state_d       = ST_FINISH;
               end else if (!is_recal_q && (cur_track_q == target_q)) begin
                  state_d = ST_SETTLE;
               end else begin
                  state_d = ST_PULSE;
               end
            end else begin
               timer_d = timer_q + 1'b1;
               state_d = ST_GAP;
            end
         end

         ST_SETTLE: begin
            if (timer_q == SETTLE_LAST) begin
               timer_d = TMR_ZERO;
               state_d = ST_FINISH;
            end else begin
               timer_d = timer_q + 1'b1;
               state_d = ST_SETTLE;
            end
         end

         ST_FINISH: begin
            done_d  = 1'b1;
            error_d = err_q;
            state_d = ST_IDLE;
         end

         default: begin
            timer_d = TMR_ZERO;
            state_d = ST_IDLE;
         end
      endcase
   end

   // output shaping: STEP mirrors the PULSE state, ready mirrors IDLE
   always_comb begin
      step_d      = (state_d != ST_PULSE);
      cmd_ready_d = (state_d == ST_IDLE);
   end

   // state and datapath registers
   always_ff @(posedge fpga_clk or negedge RESET_IN_N) begin
      if (!RESET_IN_N) begin
         state_q       <= ST_IDLE;
         timer_q       <= TMR_ZERO;
         step_cnt_q    <= CNT_ZERO;
         cur_track_q   <= TRK_ZERO;
         target_q      <= TRK_ZERO;
         track_valid_q <= 1'b0;
         is_recal_q    <= 1'b0;
         err_q         <= 1'b0;
         error_q       <= 1'b0;
         done_q        <= 1'b0;
         cmd_ready_q   <= 1'b0;
         step_q        <= 1'b1;
         dir_q         <= 1'b1;
      end else begin
         state_q       <= state_d;
         timer_q       <= timer_d;
         step_cnt_q    <= step_cnt_d;
         cur_track_q   <= cur_track_d;
         target_q      <= target_d;
         track_valid_q <= track_valid_d;
         is_recal_q    <= is_recal_d;
         err_q         <= err_d;
         error_q       <= error_d;
         done_q        <= done_d;
         cmd_ready_q   <= cmd_ready_d;
         step_q        <= step_d;
         dir_q         <= dir_d;
      end
   end

   assign cmd_ready   = cmd_ready_q;
   assign done        = done_q;
   assign error       = error_q;
   assign cur_track   = cur_track_q;
   assign track_valid = track_valid_q;
   assign STEP        = step_q;
   assign DIR         = dir_q;

endmodule

// File: tb/tb_floppy_head_stepper.sv
// Directed bench for floppy_head_stepper with a simple drive model that moves
// the head on each STEP fall and reports TRK00 at cylinder 0.
module tb_floppy_head_stepper;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       cmd_valid;
   logic       cmd_ready;
   logic [1:0] cmd_op;
   logic [6:0] cmd_track;
   logic       done;
   logic       error;
   logic [6:0] cur_track;
   logic       track_valid;
   logic       trk00_n;
   logic       step_n;
   logic       dir;

   int total = 0;
   int bad   = 0;

   // drive model / pulse monitor state
   logic step_prev = 1'b1;
   int   cyc = 0;
   int   pulses = 0;
   int   last_fall = 0;
   int   wmin = 1000, wmax = 0, pmin = 1000, pmax = 0;
   logic saw_in = 1'b0, saw_out = 1'b0;
   int   pos = 0;
   logic stuck;
   logic mon_clr;
   int   pos_init;

   floppy_head_stepper #(
      .STEP_PULSE_CYC (4),
      .STEP_RATE_CYC  (20),
      .SETTLE_CYC     (50),
      .MAX_TRACK      (79),
      .RECAL_LIMIT    (85)
   ) dut (
      .fpga_clk    (clk),
      .RESET_IN_N  (rst_n),
      .cmd_valid   (cmd_valid),
      .cmd_ready   (cmd_ready),
      .cmd_op      (cmd_op),
      .cmd_track   (cmd_track),
      .done        (done),
      .error       (error),
      .cur_track   (cur_track),
      .track_valid (track_valid),
      .TRK00       (trk00_n),
      .STEP        (step_n),
      .DIR         (dir)
   );

   always #5 clk = ~clk;

   assign trk00_n = (stuck || (pos != 0)) ? 1'b1 : 1'b0;

   // drive mechanics and STEP timing measurement
   always @(posedge clk) begin
      step_prev <= step_n;
      cyc <= cyc + 1;
      if (mon_clr) begin
         pulses  <= 0;
         wmin    <= 1000;
         wmax    <= 0;
         pmin    <= 1000;
         pmax    <= 0;
         saw_in  <= 1'b0;
         saw_out <= 1'b0;
         if (pos_init >= 0) pos <= pos_init;
      end else begin
         if (step_prev && !step_n) begin
            pulses <= pulses + 1;
            if (pulses > 0) begin
               if (cyc - last_fall < pmin) pmin <= cyc - last_fall;
               if (cyc - last_fall > pmax) pmax <= cyc - last_fall;
            end
            last_fall <= cyc;
            if (dir) begin
               saw_out <= 1'b1;
               pos <= (pos > 0) ? pos - 1 : 0;
            end else begin
               saw_in <= 1'b1;
               pos <= pos + 1;
            end
         end
         if (!step_prev && step_n) begin
            if (cyc - last_fall < wmin) wmin <= cyc - last_fall;
            if (cyc - last_fall > wmax) wmax <= cyc - last_fall;
         end
      end
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic check_rng(input string tag, input int obs, input int lo, input int hi);
      total++;
      assert (obs >= lo && obs <= hi) else begin
         bad++;
         $error("FAIL %s: observed=%0d expected=%0d..%0d", tag, obs, lo, hi);
      end
   endtask

   task automatic mon_reset(input int p, input logic st);
      @(negedge clk);
      pos_init = p;
      stuck    = st;
      mon_clr  = 1'b1;
      @(negedge clk);
      mon_clr  = 1'b0;
   endtask

   // issue one command; lat = cycles from the accept cycle to done (-1 on timeout)
   task automatic run_cmd(input logic [1:0] op, input logic [6:0] trk, input int limit,
                          output int lat, output logic first_step);
      @(negedge clk);
      cmd_valid = 1'b1;
      cmd_op    = op;
      cmd_track = trk;
      @(negedge clk);
      cmd_valid  = 1'b0;
      first_step = step_n;
      lat = 1;
      while (done !== 1'b1 && lat < limit) begin
         @(negedge clk);
         lat++;
      end
      if (done !== 1'b1) lat = -1;
   endtask

   initial begin
      int   lat;
      int   n;
      logic fs;

      rst_n = 1'b0; cmd_valid = 1'b0; cmd_op = 2'b00; cmd_track = 7'd0;
      stuck = 1'b0; mon_clr = 1'b0; pos_init = -1;

      // reset state
      mon_reset(3, 1'b0);
      repeat (3) @(negedge clk);
      check("rst_step", step_n, 1);
      check("rst_ready", cmd_ready, 0);
      check("rst_done", done, 0);
      check("rst_dir", dir, 1);
      rst_n = 1'b1;
      @(negedge clk);
      check("post_rst_ready", cmd_ready, 1);
      check("post_rst_track", cur_track, 0);
      check("post_rst_valid", track_valid, 0);
      check("post_rst_error", error, 0);

      // SEEK before any RECAL is rejected
      mon_reset(-1, 1'b0);
      run_cmd(2'b00, 7'd3, 20, lat, fs);
      check("norecal_lat", lat, 2);
      check("norecal_err", error, 1);
      check("norecal_pulses", pulses, 0);
      @(negedge clk);
      check("norecal_done_1cyc", done, 0);
      check("norecal_err_held", error, 1);

      // RECAL from cylinder 3
      mon_reset(-1, 1'b0);
      run_cmd(2'b01, 7'd0, 300, lat, fs);
      check("recal_first_step", fs, 0);
      check("recal_lat", lat, 112);
      check("recal_err", error, 0);
      check("recal_pulses", pulses, 3);
      check("recal_wmin", wmin, 4);
      check("recal_wmax", wmax, 4);
      check("recal_pmin", pmin, 20);
      check("recal_pmax", pmax, 20);
      check("recal_no_inward", saw_in, 0);
      check("recal_track", cur_track, 0);
      check("recal_valid", track_valid, 1);

      // SEEK to 80 and illegal opcode are rejected
      mon_reset(-1, 1'b0);
      run_cmd(2'b00, 7'd80, 20, lat, fs);
      check("seek80_lat", lat, 2);
      check("seek80_err", error, 1);
      check("seek80_pulses", pulses, 0);
      check("seek80_track", cur_track, 0);
      mon_reset(-1, 1'b0);
      run_cmd(2'b11, 7'd5, 20, lat, fs);
      check("badop_lat", lat, 2);
      check("badop_err", error, 1);
      check("badop_pulses", pulses, 0);

      // SEEK 0 -> 5
      mon_reset(-1, 1'b0);
      run_cmd(2'b00, 7'd5, 400, lat, fs);
      check_rng("seek5_lat", lat, 151, 153);
      check("seek5_err", error, 0);
      check("seek5_pulses", pulses, 5);
      check("seek5_no_outward", saw_out, 0);
      check("seek5_wmax", wmax, 4);
      check("seek5_pmin", pmin, 20);
      check("seek5_dir", dir, 0);
      check("seek5_track", cur_track, 5);

      // SEEK 5 -> 2
      mon_reset(-1, 1'b0);
      run_cmd(2'b00, 7'd2, 400, lat, fs);
      check_rng("seek2_lat", lat, 111, 113);
      check("seek2_pulses", pulses, 3);
      check("seek2_no_inward", saw_in, 0);
      check("seek2_dir", dir, 1);
      check("seek2_track", cur_track, 2);

      // SEEK to the current cylinder only settles
      mon_reset(-1, 1'b0);
      run_cmd(2'b00, 7'd2, 200, lat, fs);
      check("same_lat", lat, 52);
      check("same_pulses", pulses, 0);
      check("same_err", error, 0);

      // SEEK to the last legal cylinder
      mon_reset(-1, 1'b0);
      run_cmd(2'b00, 7'd79, 3000, lat, fs);
      check("seek79_lat", lat, 1592);
      check("seek79_pulses", pulses, 77);
      check("seek79_track", cur_track, 79);

      // RECAL with TRK00 stuck inactive gives up after the step limit
      mon_reset(-1, 1'b1);
      run_cmd(2'b01, 7'd0, 3000, lat, fs);
      check("stuck_lat", lat, 1702);
      check("stuck_err", error, 1);
      check("stuck_pulses", pulses, 85);
      check("stuck_valid", track_valid, 0);
      mon_reset(-1, 1'b1);
      run_cmd(2'b00, 7'd5, 20, lat, fs);
      check("after_fail_seek_lat", lat, 2);
      check("after_fail_seek_err", error, 1);

      // RECAL while already on track 0
      mon_reset(-1, 1'b0);
      repeat (3) @(negedge clk);
      run_cmd(2'b01, 7'd0, 200, lat, fs);
      check("trk0_recal_lat", lat, 52);
      check("trk0_recal_pulses", pulses, 0);
      check("trk0_recal_err", error, 0);
      check("trk0_recal_valid", track_valid, 1);

      // reset asserted during the 2nd pulse of a SEEK
      mon_reset(-1, 1'b0);
      @(negedge clk);
      cmd_valid = 1'b1; cmd_op = 2'b00; cmd_track = 7'd4;
      @(negedge clk);
      cmd_valid = 1'b0;
      n = 0;
      while (pulses < 2 && n < 200) begin
         @(negedge clk);
         n++;
      end
      check("midrst_pulses", pulses, 2);
      check("midrst_step_low", step_n, 0);
      #2 rst_n = 1'b0;
      #1 check("midrst_step_async", step_n, 1);
      @(negedge clk);
      check("midrst_track", cur_track, 0);
      check("midrst_valid", track_valid, 0);
      check("midrst_dir", dir, 1);
      check("midrst_ready", cmd_ready, 0);
      check("midrst_done", done, 0);
      repeat (4) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      check("midrst_ready_after", cmd_ready, 1);
      mon_reset(-1, 1'b0);
      run_cmd(2'b01, 7'd0, 300, lat, fs);
      check("rerecal_lat", lat, 92);
      check("rerecal_pulses", pulses, 2);
      check("rerecal_err", error, 0);
      check("rerecal_track", cur_track, 0);
      check("rerecal_valid", track_valid, 1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog expired");
   end

endmodule
